// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
package reset_seq_pkg;

    // Sequencer states:
    //   ASSERT   | all domains held in reset, stretching pulse until PLL lock
    //   WAIT_ACK | domain idx released, waiting for its synchronized ack
    //   GAP      | idle spacing before releasing the next domain
    //   RUN      | every domain released, all_ready high
    typedef enum logic [1:0] {
        ASSERT   = 2'd0,
        WAIT_ACK = 2'd1,
        GAP      = 2'd2,
        RUN      = 2'd3
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level into clk.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    (* async_reg = "true" *) logic [STAGES-1:0] sync_q;

    // Shift the raw level through the synchronizer chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Per-domain reset request sequencer: stretches reset until PLL lock, then
// releases domains in index order, each gated by the previous domain's ack.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int N_DOMAINS   = 3,
    parameter int MIN_PULSE   = 16,
    parameter int RELEASE_GAP = 8,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sw_reset_req,
    input  logic                 pll_locked,
    input  logic [N_DOMAINS-1:0] domain_ack,
    output logic [N_DOMAINS-1:0] reset_out,
    output logic                 all_ready,
    output logic                 timeout_err
);

    localparam int CNT_W = $clog2(max3(MIN_PULSE, RELEASE_GAP, ACK_TIMEOUT));
    localparam int IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(MIN_PULSE - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(RELEASE_GAP - 1);
    localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DOMAINS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

    logic                 pll_lk;
    logic                 pll_lk_q;
    logic [N_DOMAINS-1:0] ack_s;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d, idx_inc;
    logic [N_DOMAINS-1:0] reset_out_d;
    logic                 all_ready_d;
    logic                 timeout_err_d;
    logic                 abort;

    sync_bit #(.STAGES(2)) u_sync_pll (
        .clk   (clk),
        .reset (reset),
        .d     (pll_locked),
        .q     (pll_lk)
    );

    for (genvar i = 0; i < N_DOMAINS; i++) begin : g_ack_sync
        sync_bit #(.STAGES(2)) u_sync_ack (
            .clk   (clk),
            .reset (reset),
            .d     (domain_ack[i]),
            .q     (ack_s[i])
        );
    end

    // Losing lock is only acted on as an edge so a PLL that never locks
    // does not keep re-triggering the abort path.
    assign abort   = sw_reset_req | (pll_lk_q & ~pll_lk);
    assign idx_inc = idx_q + IDX_ONE;

    // Next-state, counter and output decode; abort has top priority.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        reset_out_d   = reset_out;
        all_ready_d   = all_ready;
        timeout_err_d = timeout_err;

        if (abort) begin
            state_d     = ASSERT;
            cnt_d       = '0;
            idx_d       = '0;
            reset_out_d = '1;
            all_ready_d = 1'b0;
        end else begin
            case (state_q)
                ASSERT: begin
                    reset_out_d = '1;
                    if (!pll_lk) begin
                        cnt_d = '0;
                    end else if (cnt_q == PULSE_LAST) begin
                        state_d        = WAIT_ACK;
                        reset_out_d[0] = 1'b0;
                        idx_d          = '0;
                        cnt_d          = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                WAIT_ACK: begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (ack_s[idx_q]) begin
                        if (idx_q == IDX_LAST) begin
                            state_d     = RUN;
                            all_ready_d = 1'b1;
                        end else begin
                            state_d = GAP;
                            cnt_d   = '0;
                        end
                    end else if (cnt_q == ACK_LAST) begin
                        timeout_err_d = 1'b1;
                        state_d       = ASSERT;
                        reset_out_d   = '1;
                        cnt_d         = '0;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        idx_d                = idx_inc;
                        reset_out_d[idx_inc] = 1'b0;
                        cnt_d                = '0;
                        state_d              = WAIT_ACK;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                RUN: begin
                    state_d = RUN;
                end
                default: begin
                    state_d     = ASSERT;
                    cnt_d       = '0;
                    idx_d       = '0;
                    reset_out_d = '1;
                    all_ready_d = 1'b0;
                end
            endcase
        end
    end

    // FSM, counter, lock-edge history and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ASSERT;
            cnt_q       <= '0;
            idx_q       <= '0;
            pll_lk_q    <= 1'b0;
            reset_out   <= '1;
            all_ready   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pll_lk_q    <= pll_lk;
            reset_out   <= reset_out_d;
            all_ready   <= all_ready_d;
            timeout_err <= timeout_err_d;
        end
    end

endmodule
